// File: rtl/sync_ram_pkg.sv
// Shared types and sizing helpers for the byte-enable RAM controller.
package sync_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

  // A one-word memory still needs a one-bit counter.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_ram_core.sv
// Plain DEPTH x DATA_WIDTH storage: byte-masked write and registered read sharing one address.
module sync_ram_core
  import sync_ram_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  localparam int LANES     = lane_count(DATA_WIDTH),
  localparam int AW        = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [LANES-1:0]      be,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sync_ram_be_ctrl.sv
// Valid/ready front end for sync_ram_core: clear engine FSM, range check and
// a one- or two-stage read response pipeline.
module sync_ram_be_ctrl
  import sync_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1,
  localparam int LANES     = lane_count(DATA_WIDTH),
  localparam int CW        = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_start,
  output logic                  busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LANES-1:0]      req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("sync_ram_be_ctrl: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("sync_ram_be_ctrl: DEPTH must be in 1..2**ADDR_WIDTH");
  end

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        if (cnt_reg == CW'(DEPTH - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      IDLE: begin
        if (init_start) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // req_ready drops combinationally with init_start so a clear request wins the cycle.
  always_comb begin
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state_reg)
      CLEAR:   busy = 1'b1;
      IDLE:    req_ready = !init_start;
      default: busy = 1'b1;
    endcase
  end

  logic clearing;
  logic accept;
  logic rd_accept;
  logic in_range;

  assign clearing  = (state_reg == CLEAR);
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign in_range  = ({1'b0, req_addr} < (ADDR_WIDTH + 1)'(DEPTH));

  logic                  core_we;
  logic                  core_re;
  logic [CW-1:0]         core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [LANES-1:0]      core_be;
  logic [DATA_WIDTH-1:0] core_rdata;

  assign core_we    = clearing || (accept && req_we && in_range);
  assign core_re    = rd_accept && in_range;
  assign core_addr  = clearing ? cnt_reg : req_addr[CW-1:0];
  assign core_wdata = clearing ? '0 : req_wdata;
  assign core_be    = clearing ? '1 : req_be;

  sync_ram_core #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .re    (core_re),
    .addr  (core_addr),
    .wdata (core_wdata),
    .be    (core_be),
    .rdata (core_rdata)
  );

  logic                  s1_valid_reg;
  logic                  s1_err_reg;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= rd_accept;
      s1_err_reg   <= rd_accept && !in_range;
    end
  end

  // Out-of-range reads never touch the array, so their data is forced to zero here.
  assign s1_data = s1_err_reg ? '0 : core_rdata;

  if (RD_LATENCY == 1) begin : g_lat1
    logic [DATA_WIDTH-1:0] hold_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_reg <= '0;
      end else if (s1_valid_reg) begin
        hold_reg <= s1_data;
      end
    end

    assign rsp_valid = s1_valid_reg;
    assign rsp_err   = s1_valid_reg && s1_err_reg;
    assign rsp_rdata = s1_valid_reg ? s1_data : hold_reg;
  end else if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_reg;
    logic                  s2_err_reg;
    logic [DATA_WIDTH-1:0] s2_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_reg <= 1'b0;
        s2_err_reg   <= 1'b0;
        s2_data_reg  <= '0;
      end else begin
        s2_valid_reg <= s1_valid_reg;
        s2_err_reg   <= s1_valid_reg && s1_err_reg;
        if (s1_valid_reg) begin
          s2_data_reg <= s1_data;
        end
      end
    end

    assign rsp_valid = s2_valid_reg;
    assign rsp_err   = s2_err_reg;
    assign rsp_rdata = s2_data_reg;
  end else begin : g_bad_latency
    $error("sync_ram_be_ctrl: RD_LATENCY must be 1 or 2");
  end

endmodule

// File: tb/tb_sync_ram_be_ctrl.sv
// Drives two controller instances (DEPTH 16 / latency 1 and DEPTH 12 / latency 2)
// with the same directed requests; a queue-based monitor checks every response.
module tb_sync_ram_be_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LAT_A = 1;
  localparam int LAT_B = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_start = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_be = '0;

  logic          a_busy, a_req_ready, a_rsp_valid, a_rsp_err;
  logic [DW-1:0] a_rsp_rdata;
  logic          b_busy, b_req_ready, b_rsp_valid, b_rsp_err;
  logic [DW-1:0] b_rsp_rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_ram_be_ctrl #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DEPTH (16), .RD_LATENCY (LAT_A)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .init_start (init_start), .busy (a_busy),
    .req_valid (req_valid), .req_ready (a_req_ready), .req_we (req_we),
    .req_addr (req_addr), .req_wdata (req_wdata), .req_be (req_be),
    .rsp_valid (a_rsp_valid), .rsp_rdata (a_rsp_rdata), .rsp_err (a_rsp_err)
  );

  sync_ram_be_ctrl #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DEPTH (12), .RD_LATENCY (LAT_B)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .init_start (init_start), .busy (b_busy),
    .req_valid (req_valid), .req_ready (b_req_ready), .req_we (req_we),
    .req_addr (req_addr), .req_wdata (req_wdata), .req_be (req_be),
    .rsp_valid (b_rsp_valid), .rsp_rdata (b_rsp_rdata), .rsp_err (b_rsp_err)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per presented response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_rsp_valid) begin
        if (qa.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL a_unexpected_rsp: got rdata=0x%08h err=%0b, expected no response", a_rsp_rdata, a_rsp_err);
        end else begin
          exp_t e;
          e = qa.pop_front();
          check("a_rdata", a_rsp_rdata, e.data);
          check("a_err", 32'(a_rsp_err), 32'(e.err));
          check("a_latency", 32'(cyc - e.acc), 32'(LAT_A));
          $display("[TB] a rsp rdata=0x%08h err=%0b", a_rsp_rdata, a_rsp_err);
        end
      end else begin
        check("a_idle_err", 32'(a_rsp_err), 32'd0);
      end
      if (b_rsp_valid) begin
        if (qb.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL b_unexpected_rsp: got rdata=0x%08h err=%0b, expected no response", b_rsp_rdata, b_rsp_err);
        end else begin
          exp_t e;
          e = qb.pop_front();
          check("b_rdata", b_rsp_rdata, e.data);
          check("b_err", 32'(b_rsp_err), 32'(e.err));
          check("b_latency", 32'(cyc - e.acc), 32'(LAT_B));
          $display("[TB] b rsp rdata=0x%08h err=%0b", b_rsp_rdata, b_rsp_err);
        end
      end else begin
        check("b_idle_err", 32'(b_rsp_err), 32'd0);
      end
    end
  end

  // One accepted request; for reads the expected responses of both instances are queued.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [3:0] be, input logic [DW-1:0] ea, input logic ea_err,
                        input logic [DW-1:0] eb, input logic eb_err);
    int acc;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    #1;
    acc = cyc;
    check("a_req_ready", 32'(a_req_ready), 32'd1);
    check("b_req_ready", 32'(b_req_ready), 32'd1);
    $display("[TB] req we=%0b addr=%0d wdata=0x%08h be=%04b", we, addr, wd, be);
    @(posedge clk);
    if (!we) begin
      e.data = ea; e.err = ea_err; e.acc = acc; qa.push_back(e);
      e.data = eb; e.err = eb_err; e.acc = acc; qb.push_back(e);
    end
  endtask

  task automatic idle_bus();
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_be = '0;
  endtask

  // Counts busy cycles of both instances; bounded so a stuck clear still ends.
  task automatic count_busy(input int exp_a, input int exp_b);
    int na = 0;
    int nb = 0;
    int viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_busy) na++;
      if (b_busy) nb++;
      if ((a_busy && a_req_ready) || (b_busy && b_req_ready)) viol++;
      if (!a_busy && !b_busy) break;
    end
    check("a_busy_cycles", 32'(na), 32'(exp_a));
    check("b_busy_cycles", 32'(nb), 32'(exp_b));
    check("ready_while_busy", 32'(viol), 32'd0);
    check("a_ready_after_clear", 32'(a_req_ready), 32'd1);
    check("b_ready_after_clear", 32'(b_req_ready), 32'd1);
    $display("[TB] clear done busy_a=%0d busy_b=%0d", na, nb);
  endtask

  task automatic check_in_reset();
    @(negedge clk);
    check("rst_a_busy", 32'(a_busy), 32'd1);
    check("rst_b_busy", 32'(b_busy), 32'd1);
    check("rst_a_ready", 32'(a_req_ready), 32'd0);
    check("rst_b_ready", 32'(b_req_ready), 32'd0);
    check("rst_a_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_b_valid", 32'(b_rsp_valid), 32'd0);
    check("rst_a_rdata", a_rsp_rdata, 32'd0);
    check("rst_b_rdata", b_rsp_rdata, 32'd0);
    check("rst_a_err", 32'(a_rsp_err), 32'd0);
    check("rst_b_err", 32'(b_rsp_err), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    check_in_reset();
    release_reset();
    count_busy(16, 12);

    // Freshly cleared memory reads back zero.
    do_req(1'b0, 4'd5, '0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Byte merge, read immediately after the second write.
    do_req(1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, '0, 1'b0, '0, 1'b0);
    do_req(1'b1, 4'd3, 32'h11223344, 4'b0101, '0, 1'b0, '0, 1'b0);
    do_req(1'b0, 4'd3, '0, 4'h0, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b0);

    // be=0 write is a no-op.
    do_req(1'b1, 4'd5, 32'h12345678, 4'b0000, '0, 1'b0, '0, 1'b0);
    do_req(1'b0, 4'd5, '0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Preload then four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 4'(i), 32'h10 + 32'(i), 4'b1111, '0, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 4'(i), '0, 4'h0, 32'h10 + 32'(i), 1'b0, 32'h10 + 32'(i), 1'b0);
    end

    // Address 13 is in range for the 16-word instance, out of range for the 12-word one.
    do_req(1'b1, 4'd13, 32'hFFFFFFFF, 4'b1111, '0, 1'b0, '0, 1'b0);
    do_req(1'b0, 4'd13, '0, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
    do_req(1'b0, 4'd11, '0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 4'd15, '0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Re-init: the read issued just before init_start completes with old data.
    do_req(1'b1, 4'd7, 32'hDEADBEEF, 4'b1111, '0, 1'b0, '0, 1'b0);
    do_req(1'b0, 4'd7, '0, 4'h0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    init_start = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
    #1;
    check("init_a_ready", 32'(a_req_ready), 32'd0);
    check("init_b_ready", 32'(b_req_ready), 32'd0);
    $display("[TB] init_start with pending read addr=7");
    @(posedge clk);
    #1 init_start = 1'b0; req_valid = 1'b0;
    count_busy(16, 12);
    do_req(1'b0, 4'd7, '0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 4'd13, '0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    do_req(1'b0, 4'd2, '0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of a clear restarts it from word 0.
    do_req(1'b1, 4'd9, 32'hCAFEF00D, 4'b1111, '0, 1'b0, '0, 1'b0);
    idle_bus();
    repeat (3) @(negedge clk);
    init_start = 1'b1;
    @(posedge clk);
    #1 init_start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    $display("[TB] reset asserted mid-clear");
    check_in_reset();
    release_reset();
    count_busy(16, 12);
    do_req(1'b0, 4'd9, '0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle_bus();

    repeat (5) @(negedge clk);
    check("a_pending_rsps", 32'(qa.size()), 32'd0);
    check("b_pending_rsps", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
